// File: rtl/popcnt_pipe.sv
// popcnt_pipe: pipelined masked population counter
// with a saturating running accumulator.
module popcnt_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int PIPE_STAGES = 2,
  parameter int ACC_WIDTH   = 16,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0] mask_i,
  input  logic                  mode_i,
  input  logic                  acc_en_i,
  input  logic                  clr_acc_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic                  acc_sat_o
);

  localparam int LVLS = $clog2(DATA_WIDTH);
  localparam int PW   = 1 << LVLS;
  localparam int AW1  = ACC_WIDTH + 1;

  // Spread registers evenly over the tree levels;
  // the last level always gets one so cnt_o is a flop.
  function automatic bit reg_at(int k);
    return ((k + 1) * PIPE_STAGES) / (LVLS + 1)
        != (k * PIPE_STAGES) / (LVLS + 1);
  endfunction

  logic                   adv;
  logic [DATA_WIDTH-1:0]  sel;
  logic [PW-1:0]          sel_pad;
  logic [PIPE_STAGES-1:0] vld_q, vld_d;
  logic [PIPE_STAGES-1:0] aen_q, aen_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   sat_q, sat_d;
  logic [ACC_WIDTH-1:0]   base;
  logic [ACC_WIDTH:0]     sum;

  assign adv     = ~valid_o | ready_i;
  assign ready_o = adv;
  assign sel     = (mode_i ? ~data_i : data_i) & mask_i;
  assign sel_pad = PW'(sel);

  for (genvar k = 0; k <= LVLS; k++) begin : g_lvl
    localparam int N = PW >> k;
    logic [CNT_WIDTH-1:0] node_d [N];
    logic [CNT_WIDTH-1:0] node_o [N];

    if (k == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_node
        assign node_d[i] = CNT_WIDTH'(sel_pad[i]);
      end
    end else begin : g_add
      for (genvar i = 0; i < N; i++) begin : g_node
        assign node_d[i] = g_lvl[k-1].node_o[2*i]
                         + g_lvl[k-1].node_o[2*i+1];
      end
    end

    if (reg_at(k)) begin : g_reg
      logic [CNT_WIDTH-1:0] node_q [N];
      // Tree level register; holds while the pipe stalls.
      always_ff @(posedge clk) begin
        if (rst) begin
          node_q <= '{default: '0};
        end else if (adv) begin
          node_q <= node_d;
        end
      end
      assign node_o = node_q;
    end else begin : g_comb
      assign node_o = node_d;
    end
  end

  assign cnt_o     = g_lvl[LVLS].node_o[0];
  assign valid_o   = vld_q[PIPE_STAGES-1];
  assign acc_o     = acc_q;
  assign acc_sat_o = sat_q;

  // Valid and acc-enable sideband shift with the tree.
  always_comb begin
    vld_d = vld_q;
    aen_d = aen_q;
    if (adv) begin
      vld_d = (vld_q << 1) | PIPE_STAGES'(valid_i);
      aen_d = (aen_q << 1) | PIPE_STAGES'(acc_en_i);
    end
  end

  // Clear first, then add a counted beat with saturation.
  always_comb begin
    base  = clr_acc_i ? '0 : acc_q;
    sum   = {1'b0, base} + AW1'(cnt_o);
    acc_d = base;
    sat_d = clr_acc_i ? 1'b0 : sat_q;
    if (valid_o & ready_i & aen_q[PIPE_STAGES-1]) begin
      if (sum[ACC_WIDTH]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_WIDTH-1:0];
      end
    end
  end

  // Control and accumulator state.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      aen_q <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      aen_q <= aen_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_popcnt_pipe.sv
// tb_popcnt_pipe: directed checks of popcnt_pipe
// in an 8-bit/2-stage and a 13-bit/3-stage build.
module tb_popcnt_pipe;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  logic       a_valid_i, a_ready_o, a_mode, a_acc_en, a_clr;
  logic       a_valid_o, a_ready_i, a_sat;
  logic [7:0] a_data, a_mask;
  logic [3:0] a_cnt, a_acc;

  logic        b_valid_i, b_ready_o, b_mode, b_acc_en, b_clr;
  logic        b_valid_o, b_ready_i, b_sat;
  logic [12:0] b_data, b_mask;
  logic [4:0]  b_cnt;
  logic [15:0] b_acc;

  popcnt_pipe #(
    .DATA_WIDTH(8), .PIPE_STAGES(2), .ACC_WIDTH(4)
  ) u_a (
    .clk(clk), .rst(rst),
    .valid_i(a_valid_i), .ready_o(a_ready_o),
    .data_i(a_data), .mask_i(a_mask), .mode_i(a_mode),
    .acc_en_i(a_acc_en), .clr_acc_i(a_clr),
    .valid_o(a_valid_o), .ready_i(a_ready_i),
    .cnt_o(a_cnt), .acc_o(a_acc), .acc_sat_o(a_sat)
  );

  popcnt_pipe #(
    .DATA_WIDTH(13), .PIPE_STAGES(3), .ACC_WIDTH(16)
  ) u_b (
    .clk(clk), .rst(rst),
    .valid_i(b_valid_i), .ready_o(b_ready_o),
    .data_i(b_data), .mask_i(b_mask), .mode_i(b_mode),
    .acc_en_i(b_acc_en), .clr_acc_i(b_clr),
    .valid_o(b_valid_o), .ready_i(b_ready_i),
    .cnt_o(b_cnt), .acc_o(b_acc), .acc_sat_o(b_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sent, recv, stalls;

  initial begin
    rst = 1'b1;
    a_valid_i = 0; a_data = 0; a_mask = 0; a_mode = 0;
    a_acc_en = 0; a_clr = 0; a_ready_i = 1;
    b_valid_i = 0; b_data = 0; b_mask = 0; b_mode = 0;
    b_acc_en = 0; b_clr = 0; b_ready_i = 1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid", a_valid_o, 1'b0);
    chk("rst_ready", a_ready_o, 1'b1);
    chk("rst_cnt", a_cnt, 4'd0);
    chk("rst_acc", a_acc, 4'd0);
    chk("rst_sat", a_sat, 1'b0);
    chk("rst_b_valid", b_valid_o, 1'b0);
    chk("rst_b_cnt", b_cnt, 5'd0);

    a_valid_i = 1; a_data = 8'hB5; a_mask = 8'hFF; a_mode = 0;
    tick();
    a_valid_i = 0;
    chk("lat_early", a_valid_o, 1'b0);
    tick();
    chk("lat_valid", a_valid_o, 1'b1);
    chk("ones_b5", a_cnt, 4'd5);
    tick();
    chk("lat_drop", a_valid_o, 1'b0);
    a_valid_i = 1; a_mode = 1;
    tick();
    a_valid_i = 0;
    tick();
    chk("zeros_valid", a_valid_o, 1'b1);
    chk("zeros_b5", a_cnt, 4'd3);
    tick();
    a_mode = 0;

    b_valid_i = 1; b_data = 13'h1FFF; b_mask = 13'h0F0F; b_mode = 0;
    tick();
    chk("b_lat0", b_valid_o, 1'b0);
    b_data = 13'h0; b_mask = 13'h1FFF; b_mode = 1;
    tick();
    b_valid_i = 0;
    chk("b_lat1", b_valid_o, 1'b0);
    tick();
    chk("b_valid1", b_valid_o, 1'b1);
    chk("b_mask", b_cnt, 5'd8);
    tick();
    chk("b_valid2", b_valid_o, 1'b1);
    chk("b_zeros13", b_cnt, 5'd13);
    tick();
    chk("b_drain", b_valid_o, 1'b0);

    sent = 0; recv = 0; stalls = 0;
    for (int c = 0; c < 16; c++) begin
      a_ready_i = !(c >= 3 && c <= 5);
      a_valid_i = (sent < 6);
      a_data = 8'((1 << sent) - 1);
      a_mask = 8'hFF;
      #1;
      if (a_valid_o && !a_ready_i) begin
        stalls++;
        chk("stall_ready", a_ready_o, 1'b0);
        chk("stall_cnt", a_cnt, 4'(recv));
      end else if (a_valid_o) begin
        chk("bp_order", a_cnt, 4'(recv));
        recv++;
      end
      if (a_valid_i && a_ready_o) sent++;
      tick();
    end
    a_valid_i = 0; a_ready_i = 1;
    chk("bp_total", recv, 6);
    chk("bp_stalls", stalls, 3);
    chk("acc_idle", a_acc, 4'd0);

    a_valid_i = 1; a_data = 8'h3F; a_mask = 8'hFF; a_acc_en = 1;
    tick();
    tick();
    tick();
    a_valid_i = 0;
    chk("sat_acc1", a_acc, 4'd6);
    chk("sat_flag1", a_sat, 1'b0);
    tick();
    chk("sat_acc2", a_acc, 4'd12);
    chk("sat_flag2", a_sat, 1'b0);
    tick();
    chk("sat_acc3", a_acc, 4'd15);
    chk("sat_flag3", a_sat, 1'b1);
    tick();
    chk("sat_hold", a_acc, 4'd15);

    a_clr = 1;
    tick();
    a_clr = 0;
    chk("clr_acc", a_acc, 4'd0);
    chk("clr_sat", a_sat, 1'b0);
    a_valid_i = 1; a_data = 8'h1F;
    tick();
    a_data = 8'h0F;
    tick();
    tick();
    a_valid_i = 0;
    chk("col_acc5", a_acc, 4'd5);
    tick();
    chk("col_acc9", a_acc, 4'd9);
    a_clr = 1;
    tick();
    a_clr = 0;
    chk("col_acc", a_acc, 4'd4);
    chk("col_sat", a_sat, 1'b0);

    a_valid_i = 1; a_data = 8'hFF;
    tick();
    tick();
    a_valid_i = 0;
    rst = 1;
    chk("mid_valid", a_valid_o, 1'b1);
    chk("mid_cnt", a_cnt, 4'd8);
    tick();
    rst = 0;
    chk("mrst_valid", a_valid_o, 1'b0);
    chk("mrst_ready", a_ready_o, 1'b1);
    chk("mrst_acc", a_acc, 4'd0);
    chk("mrst_cnt", a_cnt, 4'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mrst_ghost", a_valid_o, 1'b0);
    end
    chk("mrst_acc_end", a_acc, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
